// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, decode-side control
// (stall/branch) and the IF/ID pipeline register outputs.
//   master : the fetch stage (drives pcout, ifid_*, halted, fetch_count)
//   slave  : memory/decode side (drives instruction, stall, branch_*)
interface instr_fetch_if;
    logic [15:0] pcout;
    logic [15:0] instruction;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_count;

    modport master (
        output pcout, ifid_instr, ifid_pc, ifid_valid, halted, fetch_count,
        input  instruction, stall, branch_taken, branch_target
    );

    modport slave (
        input  pcout, ifid_instr, ifid_pc, ifid_valid, halted, fetch_count,
        output instruction, stall, branch_taken, branch_target
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads the instruction memory
// combinationally and captures the word into the IF/ID register. Handles
// decode stalls, branch redirect with a one-bubble flush and halt on the
// terminator word or an out-of-range PC.
// Ports:
//   clk   : clock, rising-edge
//   reset : synchronous active-high reset
//   bus   : instr_fetch_if.master (memory port, stall/branch in, IF/ID out)
module instr_fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int unsigned PC_STEP   = 2,
    parameter logic [15:0] MAX_ADDR  = 16'd54,
    parameter logic [15:0] HALT_WORD = 16'h0000
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);
    localparam int unsigned W = 16;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   pc_q, pc_d;
    logic [W-1:0]   instr_q, instr_d;
    logic [W-1:0]   ipc_q, ipc_d;
    logic           valid_q, valid_d;
    logic           halted_q, halted_d;
    logic [W-1:0]   count_q, count_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_WAIT;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            ipc_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    // Next state: branch > stall > range/halt check > normal fetch
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        ipc_d    = ipc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        count_d  = count_q;

        case (state_q)
            S_WAIT: begin
                // Memory settle cycle: no capture, PC held
                state_d = S_RUN;
            end
            S_RUN: begin
                if (bus.branch_taken) begin
                    pc_d    = {bus.branch_target[W-1:1], 1'b0};
                    valid_d = 1'b0;
                end else if (bus.stall) begin
                    // hold everything
                end else if (pc_q > MAX_ADDR || bus.instruction == HALT_WORD) begin
                    // PC stays at the halt address; halt word is never latched
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    valid_d  = 1'b0;
                end else begin
                    instr_d = bus.instruction;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + W'(PC_STEP);
                    if (count_q != {W{1'b1}}) begin
                        count_d = count_q + W'(1);
                    end
                end
            end
            S_HALT: begin
                // only reset leaves
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    assign bus.pcout       = pc_q;
    assign bus.ifid_instr  = instr_q;
    assign bus.ifid_pc     = ipc_q;
    assign bus.ifid_valid  = valid_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a default-parameter instance runs the main
// program; a MAX_ADDR=4 instance with no halt word exercises the range halt.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    instr_fetch_if bus_a ();
    instr_fetch_if bus_b ();

    instr_fetch u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    instr_fetch #(.MAX_ADDR(16'd4)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // Program image: 0 terminates at 54, every other address holds a nonzero word
    function automatic logic [15:0] mem(input logic [15:0] a);
        case (a)
            16'd0:   mem = 16'hF120;
            16'd2:   mem = 16'hF121;
            16'd4:   mem = 16'h93FF;
            16'd36:  mem = 16'hF110;
            16'd54:  mem = 16'h0000;
            default: mem = 16'hA000 | a;
        endcase
    endfunction

    assign bus_a.instruction = mem(bus_a.pcout);
    assign bus_b.instruction = mem(bus_b.pcout);
    assign bus_b.stall         = 1'b0;
    assign bus_b.branch_taken  = 1'b0;
    assign bus_b.branch_target = 16'h0000;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [15:0] ins, input logic [15:0] pc);
        chk({tag, ".instr"}, bus_a.ifid_instr, ins);
        chk({tag, ".pc"},    bus_a.ifid_pc,    pc);
        chk({tag, ".valid"}, 16'(bus_a.ifid_valid), 16'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pcout"},  bus_a.pcout,       16'h0000);
        chk({tag, ".instr"},  bus_a.ifid_instr,  16'h0000);
        chk({tag, ".ifpc"},   bus_a.ifid_pc,     16'h0000);
        chk({tag, ".valid"},  16'(bus_a.ifid_valid), 16'd0);
        chk({tag, ".halted"}, 16'(bus_a.halted), 16'd0);
        chk({tag, ".count"},  bus_a.fetch_count, 16'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus_a.stall = 1'b0;
        bus_a.branch_taken = 1'b0;
        bus_a.branch_target = 16'h0000;
        tick();
        tick();
        chk_reset_vals("rst");

        // Sequential fetch
        reset = 1'b0;
        tick();
        chk("wait.valid", 16'(bus_a.ifid_valid), 16'd0);
        chk("wait.pcout", bus_a.pcout, 16'd0);
        tick();
        chk_ifid("seq0", 16'hF120, 16'd0);
        chk("seq0.count", bus_a.fetch_count, 16'd1);
        tick();
        chk_ifid("seq1", 16'hF121, 16'd2);
        chk("seq1.pcout", bus_a.pcout, 16'd4);

        // Stall for 3 cycles; range-halt instance checked alongside
        bus_a.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.pcout", bus_a.pcout, 16'd4);
            chk_ifid("stall", 16'hF121, 16'd2);
            chk("stall.count", bus_a.fetch_count, 16'd2);
            if (i == 0) begin
                chk("oor.pc_cap4", bus_b.ifid_pc, 16'd4);
                chk("oor.pcout6",  bus_b.pcout, 16'd6);
                chk("oor.halt0",   16'(bus_b.halted), 16'd0);
            end else if (i == 1) begin
                chk("oor.halted",  16'(bus_b.halted), 16'd1);
                chk("oor.pcout",   bus_b.pcout, 16'd6);
                chk("oor.valid",   16'(bus_b.ifid_valid), 16'd0);
                chk("oor.nocap",   bus_b.ifid_pc, 16'd4);
                chk("oor.count",   bus_b.fetch_count, 16'd3);
            end
        end
        bus_a.stall = 1'b0;
        tick();
        chk_ifid("unstall", 16'h93FF, 16'd4);
        chk("unstall.count", bus_a.fetch_count, 16'd3);

        // Branch with stall also high: branch wins, odd target bit dropped
        bus_a.branch_taken = 1'b1;
        bus_a.branch_target = 16'h0025;
        bus_a.stall = 1'b1;
        tick();
        chk("br.pcout", bus_a.pcout, 16'd36);
        chk("br.valid", 16'(bus_a.ifid_valid), 16'd0);
        bus_a.branch_taken = 1'b0;
        bus_a.stall = 1'b0;
        tick();
        chk_ifid("br.tgt", 16'hF110, 16'd36);
        chk("br.count", bus_a.fetch_count, 16'd4);

        // Run 38..52 then halt at 54
        for (int a = 38; a <= 52; a += 2) begin
            tick();
            chk_ifid("run", 16'hA000 | 16'(a), 16'(a));
        end
        tick();
        chk("halt.halted", 16'(bus_a.halted), 16'd1);
        chk("halt.valid",  16'(bus_a.ifid_valid), 16'd0);
        chk("halt.pcout",  bus_a.pcout, 16'd54);
        chk("halt.count",  bus_a.fetch_count, 16'd12);
        bus_a.branch_taken = 1'b1;
        bus_a.branch_target = 16'h0000;
        tick();
        chk("halt.br_ign", bus_a.pcout, 16'd54);
        chk("halt.stay",   16'(bus_a.halted), 16'd1);
        bus_a.branch_taken = 1'b0;

        // Reset out of HALT, then run to pcout=20 and reset mid-run
        reset = 1'b1;
        tick();
        chk_reset_vals("rsthalt");
        reset = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) tick();
        chk("mid.pcout", bus_a.pcout, 16'd20);
        reset = 1'b1;
        tick();
        chk_reset_vals("rstmid");
        reset = 1'b0;
        tick();
        chk("mid.wait", 16'(bus_a.ifid_valid), 16'd0);
        tick();
        chk_ifid("mid.first", 16'hF120, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 16-bit CPU. The block owns the program counter, drives the word address into the instruction memory, and captures the returned 16-bit instruction into the IF/ID pipeline register. It handles decode-stage stalls, branch redirects with a one-bubble flush, and halt detection on the terminator word at the end of the program image.

## Interface

Parameters:

- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_STEP, 2, PC increment per fetched instruction (byte-addressed, 16-bit words).
- MAX_ADDR, 16'd54, highest valid instruction address.
- HALT_WORD, 16'h0000, instruction encoding that terminates fetch.

Ports:

- clk, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-high; the block samples it only on the rising edge of clk.
- pcout, out, 16, current fetch address to the instruction memory; registered.
- instruction, in, 16, word returned by the instruction memory for pcout, valid in the same cycle (combinational read).
- stall, in, 1, decode is not ready; hold the PC and the IF/ID contents.
- branch_taken, in, 1, redirect the fetch to branch_target.
- branch_target, in, 16, redirect address; bit 0 is forced to 0.
- ifid_instr, out, 16, latched instruction.
- ifid_pc, out, 16, address ifid_instr was fetched from.
- ifid_valid, out, 1, ifid_instr holds a real instruction (0 means bubble).
- halted, out, 1, fetch has stopped on HALT_WORD or on an out-of-range PC.
- fetch_count, out, 16, number of instructions delivered (ifid_valid rising into a new word); saturates at 16'hFFFF.

## Operation

- FSM states: WAIT, RUN, HALT.
- Reset (highest priority, any state): state goes to WAIT. Outputs take these values:
  - pcout = RESET_PC
  - ifid_instr = 16'h0000
  - ifid_pc = 16'h0000
  - ifid_valid = 0
  - halted = 0
  - fetch_count = 0
- WAIT: lasts exactly one cycle after reset is released. No capture takes place and the PC is held. The state then moves to RUN. This cycle lets the instruction memory image settle.
- RUN: the priority order for each edge is branch_taken, then stall, then halt check, then normal fetch.
  - branch_taken: pcout is set to {branch_target[15:1],1'b0} and ifid_valid goes to 0 (flush). This happens even if stall is high. The halt check is skipped for this cycle.
  - stall (no branch): pcout, ifid_instr, ifid_pc and ifid_valid all hold.
  - pcout > MAX_ADDR: state goes to HALT, halted goes to 1, ifid_valid goes to 0. No capture takes place.
  - instruction == HALT_WORD: state goes to HALT, halted goes to 1, ifid_valid goes to 0. pcout holds at the halt address.
  - Normal fetch:
    - ifid_instr is set to instruction and ifid_pc to pcout.
    - ifid_valid goes to 1.
    - pcout is set to pcout + PC_STEP, computed modulo 2^16.
    - fetch_count increments, saturating at 16'hFFFF.
- HALT: all registers hold. branch_taken and stall are ignored. Only reset leaves this state.
- Arithmetic: the PC adder is 16 bits and wraps at 16'hFFFE to 16'h0000. A wrapped PC is still subject to the MAX_ADDR check.

## Timing

- Latency from pcout to ifid_instr is 1 cycle. The address is presented in cycle N and the word is latched at the end of cycle N.
- The first valid ifid_instr appears 2 edges after reset is released (one WAIT edge, then one capture edge).
- Sustained throughput is one instruction per cycle with no stall or branch.
- A branch costs one bubble: the edge with branch_taken yields ifid_valid=0, and the next edge captures the word at the target.
- Stall and branch in the same cycle: the branch wins and the flush overrides the hold.
- The halt word is never presented with ifid_valid=1. halted rises on the same edge that ifid_valid falls.
- Reset asserted in the middle of a stall, a branch or HALT: the reset values are set on that edge, and any pending redirect is discarded.

## Test plan

- Sequential fetch: memory holds F120@0, F121@2, 93FF@4. Release reset and run 4 cycles.
  - Required: ifid = (F120,0), then (F121,2), then (93FF,4).
  - Required: ifid_valid=1 from the 2nd post-reset edge, fetch_count=3.
- Stall: assert stall for 3 cycles while ifid=(F121,2).
  - Required: pcout stays 4, ifid is unchanged, fetch_count is unchanged.
  - Required: after release, the next capture is (93FF,4).
- Branch redirect: branch_taken=1 with target 16'h0025 while stall=1.
  - Required: pcout=36 and ifid_valid=0 on the next edge.
  - Required: ifid=(F110,36) on the following edge.
- Halt: run to address 54, which holds 16'h0000.
  - Required: halted=1, ifid_valid=0, pcout=54.
  - Required: a later branch_taken to 0 leaves pcout at 54.
- Out of range: MAX_ADDR=4, program has no halt word.
  - Required: after capturing @4, pcout=6 and halted=1 on the next edge, with no capture.
- Reset mid-run: assert reset for 1 cycle while pcout=20.
  - Required: all outputs take their reset values on that edge.
  - Required: after release, one WAIT cycle, then ifid=(F120,0).
